// File: rtl/tl_rx_vc_cpl_arbiter.sv
// Round-robin lock of one RX VC's completion path onto the shared read handler / AXI completion side.
// Latency: grant registers one edge after a header becomes non-empty; mux and ctrl steering are combinational.
// Backpressure: the lock holds until i_rd_tlp_done, and idle shows all-empty flags. RX_VC_ARB_STRICT_PRIO_EN selects fixed priority.
module tl_rx_vc_cpl_arbiter #(
    parameter int NUM_VCS           = 2,
    parameter int FLAGS_WIDTH       = 6,
    parameter int CPL_HDR_EMPTY_BIT = 4,
    parameter int R_CTRL_BUS_WIDTH  = 5,
    parameter int CPL_HDR_SIZE      = 128,
    parameter int BEAT_SIZE         = 1024,
    parameter int VC_IDX_WIDTH      = 3
) (
    input  logic                                  i_clk,
    input  logic                                  i_n_rst,
    input  logic [NUM_VCS*FLAGS_WIDTH-1:0]        i_vcs_r_empty_flags,
    input  logic [NUM_VCS*CPL_HDR_SIZE-1:0]       i_vcs_cpl_hdr,
    input  logic [NUM_VCS*BEAT_SIZE-1:0]          i_vcs_cpl_data,
    output logic [NUM_VCS*R_CTRL_BUS_WIDTH-1:0]   o_vcs_r_completion_ctrl,
    input  logic [R_CTRL_BUS_WIDTH-1:0]           i_rd_r_completion_ctrl,
    input  logic                                  i_rd_tlp_done,
    output logic [FLAGS_WIDTH-1:0]                o_vcn_r_empty_flags,
    output logic [CPL_HDR_SIZE-1:0]               o_vcn_cpl_hdr,
    output logic [BEAT_SIZE-1:0]                  o_vcn_cpl_data,
    output logic                                  o_vcn_cpl_fmt_data_bit,
    output logic [9:0]                            o_vcn_cpl_length_field,
    output logic                                  o_grant_valid,
    output logic [VC_IDX_WIDTH-1:0]               o_grant_vc
);

    typedef enum logic {IDLE, LOCKED} fsm_t;

    fsm_t                    fsm, fsm_nxt;
    logic [VC_IDX_WIDTH-1:0] grant_idx, last_idx, pick_idx;
    logic [NUM_VCS-1:0]      req;
    logic                    any_req;

    always_comb begin
        req = '0;
        for (int k = 0; k < NUM_VCS; k++) begin
            req[k] = ~i_vcs_r_empty_flags[k*FLAGS_WIDTH + CPL_HDR_EMPTY_BIT];
        end
        any_req = |req;
    end

`ifdef RX_VC_ARB_STRICT_PRIO_EN
    always_comb begin
        pick_idx = '0;
        for (int k = NUM_VCS - 1; k >= 0; k--) begin
            if (req[k]) pick_idx = VC_IDX_WIDTH'(k);
        end
    end
`else
    // Lowest requester above last_idx wins; otherwise wrap to the lowest at or below it.
    logic                    hi_found;
    logic [VC_IDX_WIDTH-1:0] hi_idx, lo_idx;

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_VCS - 1; k >= 0; k--) begin
            if (req[k]) begin
                if (VC_IDX_WIDTH'(k) > last_idx) begin
                    hi_found = 1'b1;
                    hi_idx   = VC_IDX_WIDTH'(k);
                end else begin
                    lo_idx   = VC_IDX_WIDTH'(k);
                end
            end
        end
        pick_idx = hi_found ? hi_idx : lo_idx;
    end
`endif

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            fsm       <= IDLE;
            grant_idx <= '0;
            last_idx  <= VC_IDX_WIDTH'(NUM_VCS - 1);
        end else begin
            fsm <= fsm_nxt;
            if (fsm == IDLE && any_req) begin
                grant_idx <= pick_idx;
                last_idx  <= pick_idx;
            end
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (any_req)       fsm_nxt = LOCKED;
            LOCKED:  if (i_rd_tlp_done) fsm_nxt = IDLE;
            default:                    fsm_nxt = IDLE;
        endcase
    end

    // Idle presents an all-empty VC so the read handler never starts a drain.
    always_comb begin
        o_vcs_r_completion_ctrl = '0;
        o_vcn_r_empty_flags     = '1;
        o_vcn_cpl_hdr           = '0;
        o_vcn_cpl_data          = '0;
        o_grant_valid           = (fsm == LOCKED);
        o_grant_vc              = (fsm == LOCKED) ? grant_idx : '0;
        for (int k = 0; k < NUM_VCS; k++) begin
            if (fsm == LOCKED && grant_idx == VC_IDX_WIDTH'(k)) begin
                o_vcs_r_completion_ctrl[k*R_CTRL_BUS_WIDTH +: R_CTRL_BUS_WIDTH] = i_rd_r_completion_ctrl;
                o_vcn_r_empty_flags = i_vcs_r_empty_flags[k*FLAGS_WIDTH +: FLAGS_WIDTH];
                o_vcn_cpl_hdr       = i_vcs_cpl_hdr[k*CPL_HDR_SIZE +: CPL_HDR_SIZE];
                o_vcn_cpl_data      = i_vcs_cpl_data[k*BEAT_SIZE +: BEAT_SIZE];
            end
        end
    end

    assign o_vcn_cpl_fmt_data_bit = o_vcn_cpl_hdr[126];
    assign o_vcn_cpl_length_field = o_vcn_cpl_hdr[105:96];

endmodule

// File: tb/tb_tl_rx_vc_cpl_arbiter.sv
// Directed bench for tl_rx_vc_cpl_arbiter with NUM_VCS=2 and default widths.
module tb_tl_rx_vc_cpl_arbiter;

    logic          i_clk = 1'b0;
    logic          i_n_rst;
    logic [11:0]   i_vcs_r_empty_flags;
    logic [255:0]  i_vcs_cpl_hdr;
    logic [2047:0] i_vcs_cpl_data;
    logic [9:0]    o_vcs_r_completion_ctrl;
    logic [4:0]    i_rd_r_completion_ctrl;
    logic          i_rd_tlp_done;
    logic [5:0]    o_vcn_r_empty_flags;
    logic [127:0]  o_vcn_cpl_hdr;
    logic [1023:0] o_vcn_cpl_data;
    logic          o_vcn_cpl_fmt_data_bit;
    logic [9:0]    o_vcn_cpl_length_field;
    logic          o_grant_valid;
    logic [2:0]    o_grant_vc;

    int checks   = 0;
    int failures = 0;

    localparam logic [5:0] REQ  = 6'h2F;
    localparam logic [5:0] NREQ = 6'h3F;

    logic [127:0]  hdr0, hdr1;
    logic [1023:0] data0, data1;
    logic [2:0]    exp_vc;

    tl_rx_vc_cpl_arbiter dut (
        .i_clk                   (i_clk),
        .i_n_rst                 (i_n_rst),
        .i_vcs_r_empty_flags     (i_vcs_r_empty_flags),
        .i_vcs_cpl_hdr           (i_vcs_cpl_hdr),
        .i_vcs_cpl_data          (i_vcs_cpl_data),
        .o_vcs_r_completion_ctrl (o_vcs_r_completion_ctrl),
        .i_rd_r_completion_ctrl  (i_rd_r_completion_ctrl),
        .i_rd_tlp_done           (i_rd_tlp_done),
        .o_vcn_r_empty_flags     (o_vcn_r_empty_flags),
        .o_vcn_cpl_hdr           (o_vcn_cpl_hdr),
        .o_vcn_cpl_data          (o_vcn_cpl_data),
        .o_vcn_cpl_fmt_data_bit  (o_vcn_cpl_fmt_data_bit),
        .o_vcn_cpl_length_field  (o_vcn_cpl_length_field),
        .o_grant_valid           (o_grant_valid),
        .o_grant_vc              (o_grant_vc)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input logic r0, input logic r1);
        i_vcs_r_empty_flags = {(r1 ? REQ : NREQ), (r0 ? REQ : NREQ)};
    endtask

    task automatic pulse_done();
        i_rd_tlp_done = 1'b1;
        tick();
        i_rd_tlp_done = 1'b0;
        #1;
    endtask

    initial begin
        hdr0  = (128'h1 << 126) | (128'h010 << 96) | 128'hABCD;
        hdr1  = 128'h1111;
        data0 = 1024'hD0D0;
        data1 = 1024'hD1D1;
        i_n_rst                = 1'b0;
        i_vcs_cpl_hdr          = {hdr1, hdr0};
        i_vcs_cpl_data         = {data1, data0};
        i_rd_r_completion_ctrl = 5'h0A;
        i_rd_tlp_done          = 1'b0;
        set_req(1'b0, 1'b0);
        tick();
        tick();
        #1;
        chk("rst_grant_valid", o_grant_valid, 1'b0);
        chk("rst_grant_vc", o_grant_vc, 3'd0);
        chk("rst_ctrl", o_vcs_r_completion_ctrl, 10'h000);
        chk("rst_flags", o_vcn_r_empty_flags, 6'h3F);
        chk("rst_hdr", o_vcn_cpl_hdr, 128'h0);
        i_n_rst = 1'b1;

        // VC0 alone: grant after one edge, pass-through, release on done
        tick();
        set_req(1'b1, 1'b0);
        #1;
        chk("t1_pre_valid", o_grant_valid, 1'b0);
        chk("t1_pre_flags", o_vcn_r_empty_flags, 6'h3F);
        tick();
        chk("t1_valid", o_grant_valid, 1'b1);
        chk("t1_vc", o_grant_vc, 3'd0);
        chk("t1_ctrl", o_vcs_r_completion_ctrl, 10'h00A);
        chk("t1_flags", o_vcn_r_empty_flags, REQ);
        chk("t1_hdr", o_vcn_cpl_hdr, hdr0);
        chk("t1_data", o_vcn_cpl_data, data0);
        chk("t1_fmt", o_vcn_cpl_fmt_data_bit, 1'b1);
        chk("t1_len", o_vcn_cpl_length_field, 10'd16);
        i_rd_r_completion_ctrl = 5'h15;
        #1;
        chk("t1_ctrl_live", o_vcs_r_completion_ctrl, 10'h015);
        set_req(1'b0, 1'b0);
        #1;
        chk("t1_hold_no_req", o_grant_valid, 1'b1);
        pulse_done();
        chk("t1_idle_valid", o_grant_valid, 1'b0);
        chk("t1_idle_ctrl", o_vcs_r_completion_ctrl, 10'h000);
        chk("t1_idle_flags", o_vcn_r_empty_flags, 6'h3F);
        chk("t1_idle_hdr", o_vcn_cpl_hdr, 128'h0);
        chk("t1_idle_data", o_vcn_cpl_data, 1024'h0);
        chk("t1_idle_fmt", o_vcn_cpl_fmt_data_bit, 1'b0);
        chk("t1_idle_len", o_vcn_cpl_length_field, 10'd0);

        // No requests, spurious done
        i_rd_r_completion_ctrl = 5'h1F;
        pulse_done();
        chk("t5_valid", o_grant_valid, 1'b0);
        chk("t5_flags", o_vcn_r_empty_flags, 6'h3F);
        chk("t5_ctrl", o_vcs_r_completion_ctrl, 10'h000);
        tick();
        chk("t5_valid2", o_grant_valid, 1'b0);
        chk("t5_ctrl2", o_vcs_r_completion_ctrl, 10'h000);

        // Lock VC1, then async reset mid-TLP
        set_req(1'b0, 1'b1);
        tick();
        chk("t4_valid", o_grant_valid, 1'b1);
        chk("t4_vc", o_grant_vc, 3'd1);
        chk("t4_ctrl", o_vcs_r_completion_ctrl, 10'h3E0);
        chk("t4_hdr", o_vcn_cpl_hdr, hdr1);
        chk("t4_data", o_vcn_cpl_data, data1);
        #1;
        i_n_rst = 1'b0;
        #1;
        chk("t4_rst_ctrl", o_vcs_r_completion_ctrl, 10'h000);
        chk("t4_rst_valid", o_grant_valid, 1'b0);
        chk("t4_rst_flags", o_vcn_r_empty_flags, 6'h3F);
        set_req(1'b1, 1'b1);
        tick();
        i_n_rst = 1'b1;

        // Both requesting continuously: VC0 first after reset, then rotate
        for (int i = 0; i < 4; i++) begin
            tick();
`ifdef RX_VC_ARB_STRICT_PRIO_EN
            exp_vc = 3'd0;
`else
            exp_vc = 3'(i % 2);
`endif
            chk("t2_valid", o_grant_valid, 1'b1);
            chk("t2_vc", o_grant_vc, exp_vc);
            chk("t2_ctrl", o_vcs_r_completion_ctrl, (exp_vc == 3'd0) ? 10'h01F : 10'h3E0);
            pulse_done();
            chk("t2_bubble", o_grant_valid, 1'b0);
        end

        // VC1 locked; its request drops and VC0 requests before done
        set_req(1'b0, 1'b1);
        tick();
        chk("t3_vc", o_grant_vc, 3'd1);
        set_req(1'b1, 1'b0);
        tick();
        chk("t3_hold_valid", o_grant_valid, 1'b1);
        chk("t3_hold_vc", o_grant_vc, 3'd1);
        chk("t3_hold_flags", o_vcn_r_empty_flags, NREQ);
        tick();
        chk("t3_hold_vc2", o_grant_vc, 3'd1);
        pulse_done();
        chk("t3_bubble", o_grant_valid, 1'b0);
        tick();
        chk("t3_next_valid", o_grant_valid, 1'b1);
        chk("t3_next_vc", o_grant_vc, 3'd0);
        set_req(1'b0, 1'b0);
        pulse_done();
        chk("t3_end_valid", o_grant_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
